// File: rtl/dm_result_checker_pkg.sv
// chk_pkg: shared state encoding and table-entry layout for the result checker
package chk_pkg;
    localparam int CHK_N  = 14;
    localparam int CHK_AW = 8;
    localparam int CHK_DW = 8;
    typedef enum logic [1:0] {IDLE, ISSUE, CMP, FIN} chk_state_t;
    typedef struct packed {
        logic              valid;
        logic [CHK_AW-1:0] addr;
        logic [CHK_DW-1:0] data;
    } chk_entry_t;
endpackage

// File: rtl/dm_result_checker_table.sv
// chk_table: register array of check entries with one write port and a combinational read
module chk_table
    import chk_pkg::*;
#(
    parameter int N  = CHK_N,
    parameter int IW = $clog2(CHK_N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [IW-1:0] widx,
    input  chk_entry_t    wentry,
    input  logic [IW-1:0] ridx,
    output chk_entry_t    rentry
);
    chk_entry_t mem [N];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) mem[i] <= '0;
        end else if (we) begin
            mem[widx] <= wentry;
        end
    end
    assign rentry = mem[ridx];
endmodule

// File: rtl/dm_result_checker.sv
// dm_result_checker: walks the check table after done rises and records per-entry mismatches
module dm_result_checker
    import chk_pkg::*;
#(
    parameter int N_CHECKS = 14,
    parameter int AW = 8,
    parameter int DW = 8,
    localparam int IW = $clog2(N_CHECKS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                done,
    input  logic                ld_en,
    input  logic [IW-1:0]       ld_idx,
    input  logic                ld_valid,
    input  logic [AW-1:0]       ld_addr,
    input  logic [DW-1:0]       ld_data,
    output logic                rd_en,
    output logic [AW-1:0]       rd_addr,
    input  logic [DW-1:0]       rd_data,
    output logic                busy,
    output logic                check_done,
    output logic                pass,
    output logic [N_CHECKS-1:0] err_vec,
    output logic [IW:0]         err_count,
    output logic [IW-1:0]       first_err
);
    chk_state_t state;
    chk_entry_t entry;
    chk_entry_t wentry;
    logic          done_q;
    logic [IW-1:0] idx;
    logic          start;
    logic          last;
    logic          we;
    logic          mismatch;

    assign start    = done & ~done_q;
    assign last     = idx == IW'(N_CHECKS - 1);
    assign we       = ld_en && (state == IDLE || state == FIN) && ({1'b0, ld_idx} < (IW+1)'(N_CHECKS));
    assign wentry   = {ld_valid, ld_addr, ld_data};
    assign mismatch = rd_data != entry.data;
    // Read request is issued during the ISSUE cycle so the synchronous read lands in CMP
    assign rd_en    = state == ISSUE && entry.valid;
    assign rd_addr  = rd_en ? entry.addr : '0;

    chk_table #(.N(N_CHECKS), .IW(IW)) u_table (
        .clk    (clk),
        .reset  (reset),
        .we     (we),
        .widx   (ld_idx),
        .wentry (wentry),
        .ridx   (idx),
        .rentry (entry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            done_q     <= 1'b0;
            idx        <= '0;
            busy       <= 1'b0;
            check_done <= 1'b0;
            pass       <= 1'b0;
            err_vec    <= '0;
            err_count  <= '0;
            first_err  <= '0;
        end else begin
            done_q <= done;
            case (state)
                IDLE: if (start) begin
                    state      <= ISSUE;
                    idx        <= '0;
                    busy       <= 1'b1;
                    check_done <= 1'b0;
                    pass       <= 1'b0;
                    err_vec    <= '0;
                    err_count  <= '0;
                    first_err  <= '0;
                end
                ISSUE: begin
                    if (entry.valid) state <= CMP;
                    else if (last) state <= FIN;
                    else idx <= idx + 1'b1;
                end
                CMP: begin
                    if (mismatch) begin
                        err_vec[idx] <= 1'b1;
                        err_count    <= err_count + 1'b1;
                        if (err_count == '0) first_err <= idx;
                    end
                    if (last) begin
                        state <= FIN;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= ISSUE;
                    end
                end
                FIN: begin
                    busy       <= 1'b0;
                    check_done <= 1'b1;
                    pass       <= err_count == '0;
                    if (!done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dm_result_checker.sv
// tb_dm_result_checker: directed self-checking bench for dm_result_checker
module tb_dm_result_checker;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        done = 1'b0;
    logic        ld_en = 1'b0;
    logic [3:0]  ld_idx = '0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_addr = '0;
    logic [7:0]  ld_data = '0;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [7:0]  rd_data = '0;
    logic        busy;
    logic        check_done;
    logic        pass;
    logic [13:0] err_vec;
    logic [4:0]  err_count;
    logic [3:0]  first_err;

    logic [7:0] mem [256];
    int n_assert = 0;
    int n_fail = 0;
    int cyc = 0;
    int rd_cnt = 0;
    logic [7:0] last_addr = '0;

    dm_result_checker dut (
        .clk        (clk),
        .reset      (reset),
        .done       (done),
        .ld_en      (ld_en),
        .ld_idx     (ld_idx),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .check_done (check_done),
        .pass       (pass),
        .err_vec    (err_vec),
        .err_count  (err_count),
        .first_err  (first_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
            rd_cnt = rd_cnt + 1;
            last_addr = rd_addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [3:0] i, input logic v, input logic [7:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_idx = i; ld_valid = v; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; done = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic start_run();
        done = 1'b1;
        tick();
        cyc = 0;
    endtask

    task automatic wait_fin(input string tag, input int exp_lat);
        int guard = 0;
        while (!check_done && guard < 200) begin
            tick();
            guard++;
        end
        chk(tag, cyc, exp_lat);
    endtask

    task automatic end_run();
        done = 1'b0;
        tick();
        tick();
    endtask

    task automatic load_three();
        load(4'd0, 1'b1, 8'd3, 8'hF0);
        load(4'd1, 1'b1, 8'd2, 8'h01);
        load(4'd2, 1'b1, 8'd5, 8'hAA);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[3] = 8'hF0; mem[2] = 8'h01; mem[5] = 8'hAA;
        tick(); tick();
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_check_done", check_done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err_vec", err_vec, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_first_err", first_err, 0);
        chk("rst_rd_en", rd_en, 0);

        // 3 valid + 11 skipped: 1 + 2*3 + 11 = 18
        load_three();
        rd_cnt = 0;
        start_run();
        chk("t1_busy", busy, 1);
        wait_fin("t1_latency", 18);
        chk("t1_pass", pass, 1);
        chk("t1_err_vec", err_vec, 0);
        chk("t1_err_count", err_count, 0);
        chk("t1_busy_fin", busy, 0);
        chk("t1_rd_cnt", rd_cnt, 3);
        end_run();

        mem[2] = 8'h02;
        start_run();
        wait_fin("t2_latency", 18);
        chk("t2_err_vec", err_vec, 14'b10);
        chk("t2_err_count", err_count, 1);
        chk("t2_first_err", first_err, 1);
        chk("t2_pass", pass, 0);
        end_run();
        chk("t2_hold_done", check_done, 1);
        chk("t2_hold_vec", err_vec, 14'b10);

        mem[3] = 8'h00; mem[5] = 8'h00;
        start_run();
        wait_fin("t3_latency", 18);
        chk("t3_err_vec", err_vec, 14'b111);
        chk("t3_err_count", err_count, 3);
        chk("t3_first_err", first_err, 0);
        end_run();
        mem[3] = 8'hF0; mem[5] = 8'hAA; mem[2] = 8'h01;

        // only the last entry valid: 1 + 2 + 13 = 16
        do_reset();
        mem[12] = 8'h01;
        load(4'd13, 1'b1, 8'd12, 8'h00);
        rd_cnt = 0;
        start_run();
        wait_fin("t4_latency", 16);
        chk("t4_rd_cnt", rd_cnt, 1);
        chk("t4_rd_addr", last_addr, 12);
        chk("t4_err_vec", err_vec, 14'h2000);
        chk("t4_first_err", first_err, 13);
        chk("t4_err_count", err_count, 1);
        end_run();

        // reset while comparing entry 1, then an empty-table run
        do_reset();
        load_three();
        start_run();
        tick(); tick(); tick();
        reset = 1'b1; done = 1'b0;
        tick();
        reset = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_check_done", check_done, 0);
        chk("t5_err_vec", err_vec, 0);
        chk("t5_rd_en", rd_en, 0);
        start_run();
        wait_fin("t5_latency", 15);
        chk("t5_pass", pass, 1);
        end_run();

        // done glitches mid-run must not restart
        do_reset();
        mem[2] = 8'h02;
        load_three();
        start_run();
        tick(); tick(); tick();
        done = 1'b0;
        tick(); tick();
        done = 1'b1;
        wait_fin("t6_latency", 18);
        chk("t6_err_count", err_count, 1);
        chk("t6_err_vec", err_vec, 14'b10);
        for (int i = 0; i < 5; i++) tick();
        chk("t6_hold_done", check_done, 1);
        chk("t6_hold_busy", busy, 0);
        done = 1'b0;
        tick();
        mem[2] = 8'h01;
        start_run();
        chk("t6_rerun_vec", err_vec, 0);
        chk("t6_rerun_done", check_done, 0);
        chk("t6_rerun_busy", busy, 1);
        wait_fin("t6_rerun_latency", 18);
        chk("t6_rerun_pass", pass, 1);

        // table writes are ignored while busy, accepted in FIN
        done = 1'b0;
        tick();
        start_run();
        load(4'd1, 1'b1, 8'd2, 8'h55);
        wait_fin("t7_latency", 18);
        chk("t7_pass_busy_load", pass, 1);
        chk("t7_err_vec", err_vec, 0);
        load(4'd1, 1'b1, 8'd2, 8'h55);
        done = 1'b0;
        tick();
        start_run();
        wait_fin("t7_fin_latency", 18);
        chk("t7_fin_load_vec", err_vec, 14'b10);
        chk("t7_fin_load_pass", pass, 0);
        end_run();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
